// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered grants that are held until the owner releases them.
// The optional forced release after MAX_HOLD cycles is compiled in with RR_HOLD_ARB_TIMEOUT_EN.
module rr_hold_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         done,
  output logic [WIDTH-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(WIDTH)-1:0] grant_id,
  output logic                     timeout
);

  localparam int IDW = $clog2(WIDTH);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  if (WIDTH < 2 || WIDTH > 16 || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_hold_arbiter: WIDTH must be 2..16 and MAX_HOLD >= 2");
  end

  // Returns {found, index}: first set bit of r searching upward from p+1, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [WIDTH-1:0] r,
                                           input logic [IDW-1:0]   p);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] sel;
    int             pos;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      pos = (int'(p) + i) % WIDTH;
      sel = IDW'(pos);
      if (!found && r[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
    return {found, idx};
  endfunction

  logic             state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;

  logic [IDW-1:0]   owner;
  logic             owner_release;
  logic             expire;
  logic [IDW:0]     pick_idle;
  logic [IDW:0]     pick_next;

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign expire  = (cnt_q == CW'(MAX_HOLD - 1));
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign owner         = grant_id_q;
  assign owner_release = done[owner] | ~req[owner];
  assign pick_idle     = rr_pick(req, ptr_q);
  // The releasing owner is masked so it can only win again through IDLE.
  assign pick_next     = rr_pick(req & ~grant_q, owner);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      if (pick_idle[IDW]) begin
        state_d       = ST_OWN;
        grant_id_d    = pick_idle[IDW-1:0];
        grant_d       = WIDTH'(1) << pick_idle[IDW-1:0];
        grant_valid_d = 1'b1;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end
    end else if (owner_release || expire) begin
      ptr_d = owner;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = expire & ~owner_release;
`endif
      if (pick_next[IDW]) begin
        grant_id_d    = pick_next[IDW-1:0];
        grant_d       = WIDTH'(1) << pick_next[IDW-1:0];
        grant_valid_d = 1'b1;
      end else begin
        state_d       = ST_IDLE;
        grant_id_d    = '0;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    end else begin
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      if (cnt_q != CW'(MAX_HOLD - 1)) cnt_d = cnt_q + CW'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDW'(WIDTH - 1);
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: directed scenarios followed by random traffic,
// predicted by an owner/pointer model of the round-robin rules.
module tb_rr_hold_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] req = '0;
  logic [W-1:0] done = '0;
  logic [W-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         timeout;

  rr_hold_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic         v;
    logic [1:0]   id;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Reference state: owner index (-1 when idle), last-owner pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = W - 1;
  int m_cnt   = 0;

  function automatic int pick(input logic [W-1:0] r, input int p);
    for (int i = 1; i <= W; i++) begin
      if (r[(p + i) % W]) return (p + i) % W;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = W - 1;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic [W-1:0] d, output exp_t e);
    bit to;
    bit rel;
    bit expd;
    logic [W-1:0] m;
    to = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      rel  = d[m_owner] || !r[m_owner];
      expd = TO_EN && (m_cnt == MH - 1);
      if (rel || expd) begin
        m_ptr = m_owner;
        m = r;
        m[m_owner] = 1'b0;
        m_owner = pick(m, m_ptr);
        m_cnt = 0;
        to = expd && !rel;
      end else if (m_cnt < MH - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
    e.g  = (m_owner >= 0) ? (W'(1) << m_owner) : '0;
    e.v  = (m_owner >= 0);
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.to = to;
  endtask

  task automatic step(input logic [W-1:0] r, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    req  = r;
    done = d;
    model_step(r, d, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp_cnt++;
      if (grant !== mon_e.g || grant_valid !== mon_e.v || grant_id !== mon_e.id ||
          timeout !== mon_e.to) begin
        fail_cnt++;
        $display("FAIL outputs @%0t: grant=%b valid=%b id=%0d timeout=%b, expected grant=%b valid=%b id=%0d timeout=%b",
                 $time, grant, grant_valid, grant_id, timeout,
                 mon_e.g, mon_e.v, mon_e.id, mon_e.to);
      end
      cmp_cnt++;
      if (!$onehot0(grant)) begin
        fail_cnt++;
        $display("FAIL onehot @%0t: grant=%b is not one-hot or zero", $time, grant);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_valid", 32'(grant_valid), 32'h0);
    chk("reset_id", 32'(grant_id), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    #1 rst = 1'b0;
    model_reset();

    // Grant to 1, then back-to-back handover to 3 on done.
    step(4'b1010, 4'b0000);
    step(4'b1010, 4'b0000);
    step(4'b1010, 4'b0010);
    step(4'b1010, 4'b0000);
    step(4'b0000, 4'b0000);

    // Fairness with everyone requesting; each owner releases after two cycles.
    step(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000);
      step(4'b1111, W'(1) << m_owner);
    end
    step(4'b0000, 4'b0000);

    // Owner 2 ignores foreign done and toggling req[0].
    step(4'b0100, 4'b0000);
    for (int i = 0; i < 6; i++) step({2'b01, 1'b0, 1'(i)}, 4'b0001);
    step(4'b0000, 4'b0000);

    // Withdrawal to idle, reacquire, then pointer favours req[1].
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0011, 4'b0000);
    step(4'b0011, 4'b0000);
    step(4'b0000, 4'b0000);

    // Asynchronous reset while owner 2 holds.
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0000);
    @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_valid", 32'(grant_valid), 32'h0);
    chk("async_rst_id", 32'(grant_id), 32'h0);
    model_reset();
    req = 4'b1001;
    done = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    step(4'b1001, 4'b0000);
    step(4'b1001, 4'b0001);
    step(4'b1001, 4'b0000);
    step(4'b0000, 4'b0000);

    // Long hold with two requesters: forced rotation only when the timeout is built in.
    for (int i = 0; i < 12; i++) step(4'b0011, 4'b0000);
    step(4'b0000, 4'b0000);

    // Random traffic.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = W'($urandom);
      d = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      step(r, d);
    end

    @(negedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
